// File: rtl/parking_pkg.sv
// Shared types and default sizing for the parking gate controller.
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTER = 2'd1,
    EXIT  = 2'd2,
    GATE  = 2'd3
  } state_t;

  localparam int NUM_SLOTS_DEF     = 3;
  localparam int TIME_W_DEF        = 10;
  localparam int RATE_DEF          = 2;
  localparam int GATE_OPEN_CYC_DEF = 5;

  // Slot indices are always 2 bits wide, so at most four slots.
  localparam int SLOT_W = 2;

  localparam logic [TIME_W_DEF-1:0] FEE_MAX = {TIME_W_DEF{1'b1}};

endpackage

// File: rtl/parking_slot_alloc.sv
// Lowest-index free slot finder; free_slot is 0 when the lot is full.
module parking_slot_alloc
  import parking_pkg::*;
#(
  parameter int NUM_SLOTS = NUM_SLOTS_DEF
) (
  input  logic [NUM_SLOTS-1:0] occupied,
  output logic [SLOT_W-1:0]    free_slot,
  output logic                 full
);

  // Scan from the top down so the lowest free index wins.
  always_comb begin
    free_slot = '0;
    full      = 1'b1;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!occupied[i]) begin
        free_slot = SLOT_W'(i);
        full      = 1'b0;
      end
    end
  end

endmodule

// File: rtl/parking_gate_controller.sv
// Shared entry/exit gate sequencer with per-slot arrival stamps and exit fee.
//
// state | meaning
// IDLE  | waiting for a request; arbitrates entry vs exit
// ENTER | allocate lowest free slot or reject when full
// EXIT  | validate slot, compute fee, free the slot or reject
// GATE  | gate held open for GATE_OPEN_CYC cycles
module parking_gate_controller
  import parking_pkg::*;
#(
  parameter int NUM_SLOTS     = NUM_SLOTS_DEF,
  parameter int TIME_W        = TIME_W_DEF,
  parameter int RATE          = RATE_DEF,
  parameter int GATE_OPEN_CYC = GATE_OPEN_CYC_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 enter_req,
  input  logic                 exit_req,
  input  logic [SLOT_W-1:0]    exit_slot,
  output logic                 enter_ack,
  output logic                 enter_reject,
  output logic                 exit_ack,
  output logic                 exit_reject,
  output logic [SLOT_W-1:0]    assigned_slot,
  output logic [NUM_SLOTS-1:0] occupied,
  output logic [TIME_W-1:0]    fee,
  output logic                 fee_valid,
  output logic                 gate_open,
  output logic                 busy,
  output logic [TIME_W-1:0]    time_now
);

  localparam int CNT_W = $clog2(GATE_OPEN_CYC + 1);
  localparam logic [CNT_W-1:0] GATE_LOAD = CNT_W'(GATE_OPEN_CYC - 1);
  localparam logic [2*TIME_W-1:0] FEE_LIM = {{TIME_W{1'b0}}, {TIME_W{1'b1}}};

  state_t              state;
  state_t              next_state;
  logic                pri_exit;
  logic [SLOT_W-1:0]   exit_slot_q;
  logic [SLOT_W-1:0]   assigned_q;
  logic [SLOT_W-1:0]   free_slot;
  logic                full;
  logic                slot_ok;
  logic                enter_go;
  logic                exit_go;
  logic [TIME_W-1:0]   stamp [NUM_SLOTS];
  logic [TIME_W-1:0]   fee_q;
  logic [TIME_W-1:0]   elapsed;
  logic [TIME_W-1:0]   fee_calc;
  logic [2*TIME_W-1:0] product;
  logic [CNT_W-1:0]    gate_cnt;

  parking_slot_alloc #(
    .NUM_SLOTS (NUM_SLOTS)
  ) u_slot_alloc (
    .occupied  (occupied),
    .free_slot (free_slot),
    .full      (full)
  );

  // Exit slot is latched in IDLE so a glitch on exit_slot cannot change the
  // slot mid-transaction. The out-of-range test guards the occupancy lookup.
  assign slot_ok  = (int'(exit_slot_q) < NUM_SLOTS) && occupied[exit_slot_q];
  assign enter_go = (state == ENTER) && !full;
  assign exit_go  = (state == EXIT) && slot_ok;

  // Modular subtraction handles time counter wrap; the wide product saturates.
  assign elapsed  = time_now - stamp[exit_slot_q];
  assign product  = {{TIME_W{1'b0}}, elapsed} * (2*TIME_W)'(RATE);
  assign fee_calc = (product > FEE_LIM) ? {TIME_W{1'b1}} : product[TIME_W-1:0];

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic, including alternating priority on simultaneous requests.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (enter_req && exit_req) begin
          next_state = pri_exit ? EXIT : ENTER;
        end else if (exit_req) begin
          next_state = EXIT;
        end else if (enter_req) begin
          next_state = ENTER;
        end
      end
      ENTER:   next_state = full ? IDLE : GATE;
      EXIT:    next_state = slot_ok ? GATE : IDLE;
      GATE:    next_state = (gate_cnt == '0) ? IDLE : GATE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs; slot and fee show the new value in the ack cycle, then hold.
  always_comb begin
    enter_ack     = enter_go;
    enter_reject  = (state == ENTER) && full;
    exit_ack      = exit_go;
    exit_reject   = (state == EXIT) && !slot_ok;
    fee_valid     = exit_go;
    gate_open     = (state == GATE);
    busy          = (state != IDLE);
    assigned_slot = enter_go ? free_slot : assigned_q;
    fee           = exit_go ? fee_calc : fee_q;
  end

  // Time base, slot bookkeeping, priority pointer and gate down-counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      time_now    <= '0;
      occupied    <= '0;
      assigned_q  <= '0;
      fee_q       <= '0;
      gate_cnt    <= '0;
      pri_exit    <= 1'b1;
      exit_slot_q <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        stamp[i] <= '0;
      end
    end else begin
      if (tick) begin
        time_now <= time_now + TIME_W'(1);
      end
      if (state == IDLE) begin
        exit_slot_q <= exit_slot;
        if (enter_req && exit_req) begin
          pri_exit <= ~pri_exit;
        end
      end
      if (enter_go) begin
        occupied[free_slot] <= 1'b1;
        stamp[free_slot]    <= time_now;
        assigned_q          <= free_slot;
        gate_cnt            <= GATE_LOAD;
      end
      if (exit_go) begin
        occupied[exit_slot_q] <= 1'b0;
        fee_q                 <= fee_calc;
        gate_cnt              <= GATE_LOAD;
      end
      if ((state == GATE) && (gate_cnt != '0)) begin
        gate_cnt <= gate_cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_parking_gate_controller.sv
// Bench for parking_gate_controller: directed scenarios plus random traffic
// checked against a transaction-level model of the lot.
module tb_parking_gate_controller;

  localparam int NS   = 3;
  localparam int TW   = 10;
  localparam int RATE = 2;
  localparam int GOC  = 5;
  localparam int TMOD = 1 << TW;
  localparam int TMAX = TMOD - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          tick = 1'b0;
  logic          enter_req = 1'b0;
  logic          exit_req = 1'b0;
  logic [1:0]    exit_slot = 2'd0;
  logic          enter_ack, enter_reject, exit_ack, exit_reject;
  logic          fee_valid, gate_open, busy;
  logic [1:0]    assigned_slot;
  logic [NS-1:0] occupied;
  logic [TW-1:0] fee, time_now;

  parking_gate_controller #(
    .NUM_SLOTS     (NS),
    .TIME_W        (TW),
    .RATE          (RATE),
    .GATE_OPEN_CYC (GOC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .tick          (tick),
    .enter_req     (enter_req),
    .exit_req      (exit_req),
    .exit_slot     (exit_slot),
    .enter_ack     (enter_ack),
    .enter_reject  (enter_reject),
    .exit_ack      (exit_ack),
    .exit_reject   (exit_reject),
    .assigned_slot (assigned_slot),
    .occupied      (occupied),
    .fee           (fee),
    .fee_valid     (fee_valid),
    .gate_open     (gate_open),
    .busy          (busy),
    .time_now      (time_now)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [TW-1:0] m_time;
  logic [NS-1:0] m_occ;
  int            m_stamp [NS];
  logic [1:0]    m_assigned;
  logic [TW-1:0] m_fee;
  bit            m_pri_exit;
  bit            rnd_tick = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  function automatic void model_reset();
    m_time     = '0;
    m_occ      = '0;
    m_assigned = '0;
    m_fee      = '0;
    m_pri_exit = 1'b1;
    for (int i = 0; i < NS; i++) m_stamp[i] = 0;
  endfunction

  // One clock: the model sees the same tick/reset the DUT sampled.
  task automatic cycle();
    @(posedge clk);
    if (!reset) model_reset();
    else m_time = m_time + TW'(tick);
    #1;
    tick = rnd_tick ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  task automatic advance_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cycle();
    end
    tick = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    enter_req = 1'b0;
    exit_req = 1'b0;
    cycle();
    cycle();
    reset = 1'b1;
  endtask

  // One full request: arbitration, ack/reject, gate window, return to idle.
  task automatic transact(input bit en, input bit ex, input logic [1:0] slot, input string tag);
    bit serve_exit, grant, ok;
    int s, elapsed, prod;
    logic [4:0] exp_pulse;
    if (en && ex) begin
      serve_exit = m_pri_exit;
      m_pri_exit = ~m_pri_exit;
    end else begin
      serve_exit = ex;
    end
    enter_req = en;
    exit_req  = ex;
    exit_slot = slot;
    cycle();
    grant = 1'b0;
    if (!serve_exit) begin
      if (m_occ == '1) begin
        exp_pulse = 5'b01000;
      end else begin
        s = 0;
        while (m_occ[s]) s++;
        m_occ[s]   = 1'b1;
        m_stamp[s] = int'(m_time);
        m_assigned = 2'(s);
        grant      = 1'b1;
        exp_pulse  = 5'b10000;
      end
    end else begin
      ok = 1'b0;
      if (int'(slot) < NS) ok = m_occ[slot];
      if (ok) begin
        elapsed     = (int'(m_time) - m_stamp[slot] + TMOD) % TMOD;
        prod        = elapsed * RATE;
        m_fee       = (prod > TMAX) ? TW'(TMAX) : TW'(prod);
        m_occ[slot] = 1'b0;
        grant       = 1'b1;
        exp_pulse   = 5'b00101;
      end else begin
        exp_pulse = 5'b00010;
      end
    end
    n_checks++;
    if ({enter_ack, enter_reject, exit_ack, exit_reject, fee_valid} !== exp_pulse) begin
      n_errors++;
      $display("FAIL %s pulses {eack,erej,xack,xrej,fv}: got %b expected %b", tag,
               {enter_ack, enter_reject, exit_ack, exit_reject, fee_valid}, exp_pulse);
    end
    n_checks++;
    if (assigned_slot !== m_assigned) begin
      n_errors++;
      $display("FAIL %s assigned_slot: got %0d expected %0d", tag, assigned_slot, m_assigned);
    end
    n_checks++;
    if (fee !== m_fee) begin
      n_errors++;
      $display("FAIL %s fee: got %0d expected %0d", tag, fee, m_fee);
    end
    n_checks++;
    if ({gate_open, busy} !== 2'b01 || time_now !== m_time) begin
      n_errors++;
      $display("FAIL %s decision cycle gate/busy/time: got %b/%0d expected 01/%0d", tag,
               {gate_open, busy}, time_now, m_time);
    end
    enter_req = 1'b0;
    exit_req  = 1'b0;
    cycle();
    n_checks++;
    if (occupied !== m_occ) begin
      n_errors++;
      $display("FAIL %s occupied: got %b expected %b", tag, occupied, m_occ);
    end
    n_checks++;
    if ({gate_open, busy} !== {grant, grant} ||
        {enter_ack, enter_reject, exit_ack, exit_reject, fee_valid} !== 5'b0) begin
      n_errors++;
      $display("FAIL %s first gate cycle gate/busy/pulses: got %b/%b expected %b/00000", tag,
               {gate_open, busy}, {enter_ack, enter_reject, exit_ack, exit_reject, fee_valid},
               {grant, grant});
    end
    if (grant) begin
      for (int i = 1; i < GOC; i++) begin
        cycle();
        n_checks++;
        if (gate_open !== 1'b1) begin
          n_errors++;
          $display("FAIL %s gate_open open cycle %0d: got %b expected 1", tag, i + 1, gate_open);
        end
      end
      cycle();
      n_checks++;
      if ({gate_open, busy} !== 2'b00 || time_now !== m_time) begin
        n_errors++;
        $display("FAIL %s gate close gate/busy/time: got %b/%0d expected 00/%0d", tag,
                 {gate_open, busy}, time_now, m_time);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({enter_ack, enter_reject, exit_ack, exit_reject, fee_valid, gate_open, busy} !== 7'b0 ||
        assigned_slot !== 2'd0 || occupied !== '0 || fee !== '0 || time_now !== '0) begin
      n_errors++;
      $display("FAIL reset outputs: pulses/gate/busy=%b slot=%0d occ=%b fee=%0d time=%0d expected all 0",
               {enter_ack, enter_reject, exit_ack, exit_reject, fee_valid, gate_open, busy},
               assigned_slot, occupied, fee, time_now);
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int k = 0; k < NS; k++) begin
      transact(1'b1, 1'b0, 2'd0, "fill");
      n_checks++;
      if (assigned_slot !== 2'(k)) begin
        n_errors++;
        $display("FAIL fill assigned_slot: got %0d expected %0d", assigned_slot, k);
      end
      advance_ticks(10);
    end
    transact(1'b1, 1'b0, 2'd0, "full_reject");
    n_checks++;
    if (occupied !== 3'b111) begin
      n_errors++;
      $display("FAIL fill occupied: got %b expected 111", occupied);
    end
  endtask

  task automatic test_fee();
    do_reset();
    advance_ticks(4);
    transact(1'b1, 1'b0, 2'd0, "fee_enter");
    advance_ticks(7);
    transact(1'b0, 1'b1, 2'd0, "fee_exit");
    n_checks++;
    if (fee !== 10'd14 || occupied[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL fee basic fee/occ0: got %0d/%b expected 14/0", fee, occupied[0]);
    end
  endtask

  task automatic test_priority();
    do_reset();
    transact(1'b1, 1'b0, 2'd0, "prio_fill0");
    transact(1'b1, 1'b0, 2'd0, "prio_fill1");
    transact(1'b1, 1'b1, 2'd1, "prio_both_a");
    n_checks++;
    if (occupied !== 3'b001) begin
      n_errors++;
      $display("FAIL priority exit first occupied: got %b expected 001", occupied);
    end
    transact(1'b1, 1'b1, 2'd0, "prio_both_b");
    n_checks++;
    if (occupied !== 3'b011 || assigned_slot !== 2'd1) begin
      n_errors++;
      $display("FAIL priority enter second occ/slot: got %b/%0d expected 011/1", occupied, assigned_slot);
    end
  endtask

  task automatic test_wrap_saturate();
    do_reset();
    advance_ticks(1020);
    transact(1'b1, 1'b0, 2'd0, "wrap_enter");
    advance_ticks(10);
    n_checks++;
    if (time_now !== 10'd6) begin
      n_errors++;
      $display("FAIL wrap time_now: got %0d expected 6", time_now);
    end
    transact(1'b0, 1'b1, 2'd0, "wrap_exit");
    n_checks++;
    if (fee !== 10'd20) begin
      n_errors++;
      $display("FAIL wrap fee: got %0d expected 20", fee);
    end
    transact(1'b1, 1'b0, 2'd0, "sat_enter");
    advance_ticks(600);
    transact(1'b0, 1'b1, 2'd0, "sat_exit");
    n_checks++;
    if (fee !== 10'd1023) begin
      n_errors++;
      $display("FAIL saturate fee: got %0d expected 1023", fee);
    end
  endtask

  task automatic test_reject();
    do_reset();
    transact(1'b1, 1'b0, 2'd0, "rej_fill0");
    transact(1'b1, 1'b0, 2'd0, "rej_fill1");
    advance_ticks(3);
    transact(1'b0, 1'b1, 2'd1, "rej_setup_exit");
    transact(1'b0, 1'b1, 2'd3, "rej_out_of_range");
    transact(1'b0, 1'b1, 2'd2, "rej_empty");
    n_checks++;
    if (fee !== 10'd6 || occupied !== 3'b001) begin
      n_errors++;
      $display("FAIL reject preserved fee/occ: got %0d/%b expected 6/001", fee, occupied);
    end
  endtask

  task automatic test_reset_mid_gate();
    do_reset();
    advance_ticks(5);
    enter_req = 1'b1;
    cycle();
    enter_req = 1'b0;
    cycle();
    cycle();
    cycle();
    n_checks++;
    if (gate_open !== 1'b1 || time_now !== 10'd5) begin
      n_errors++;
      $display("FAIL midgate pre-reset gate/time: got %b/%0d expected 1/5", gate_open, time_now);
    end
    reset = 1'b0;
    cycle();
    n_checks++;
    if (gate_open !== 1'b0 || occupied !== '0 || time_now !== '0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL midgate reset gate/occ/time/busy: got %b/%b/%0d/%b expected 0/000/0/0",
               gate_open, occupied, time_now, busy);
    end
    reset = 1'b1;
  endtask

  task automatic test_random();
    bit en, ex;
    do_reset();
    rnd_tick = 1'b1;
    for (int n = 0; n < 60; n++) begin
      en = 1'($urandom_range(0, 1));
      ex = 1'($urandom_range(0, 1));
      if (!en && !ex) en = 1'b1;
      transact(en, ex, 2'($urandom_range(0, 3)), "random");
      for (int g = 0; g < int'($urandom_range(0, 4)); g++) cycle();
    end
    rnd_tick = 1'b0;
    tick = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1);
  end

  initial begin
    model_reset();
    test_reset();
    test_fill();
    test_fee();
    test_priority();
    test_wrap_saturate();
    test_reject();
    test_reset_mid_gate();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
